// File: rtl/cla_pkg.sv
// Shared constants and lookahead helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int CLA_GROUP = 4;

    function automatic logic grp_p(input logic [CLA_GROUP-1:0] p);
        return &p;
    endfunction

    function automatic logic grp_g(input logic [CLA_GROUP-1:0] g,
                                   input logic [CLA_GROUP-1:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result streaming bus of the pipelined adder, with valid/ready on both sides.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group; c3_o is the carry into bit 3 for overflow detection.
module cla_group4
    import cla_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a_i,
    input  logic [CLA_GROUP-1:0] b_i,
    input  logic                 ci_i,
    output logic [CLA_GROUP-1:0] s_o,
    output logic                 co_o,
    output logic                 c3_o
);

    logic [CLA_GROUP-1:0] p_s;
    logic [CLA_GROUP-1:0] g_s;
    logic [CLA_GROUP-1:0] c_s;

    // Bit-level lookahead carries, sum and group carry-out.
    always_comb begin
        p_s    = a_i ^ b_i;
        g_s    = a_i & b_i;
        c_s[0] = ci_i;
        c_s[1] = g_s[0] | (p_s[0] & ci_i);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci_i);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & ci_i);
        s_o    = p_s ^ c_s;
        co_o   = grp_g(g_s, p_s) | (grp_p(p_s) & ci_i);
        c3_o   = c_s[3];
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit group per stage, operands
// skewed in and sums de-skewed out so a beat's result emerges STAGES cycles later.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    cla_pipe_adder_if.slave bus
);

    localparam int STAGES = WIDTH / CLA_GROUP;
    localparam logic [STAGES-1:0] MSB_GRP_SEL = STAGES'(1) << (STAGES - 1);

    logic             stall_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;

    // Layer 0 is the input register; layer k+1 holds the output of stage k.
    logic [STAGES:0]   v_q;
    logic [STAGES:0]   c_q;
    logic              ovf_q;
    logic [STAGES-1:0] co_s;
    logic [STAGES-1:0] c3_s;
    logic [WIDTH-1:0]  s_s;

    assign stall_s      = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall_s;

    // Subtraction is a + ~b + 1, so the carry-in is forced high.
    always_comb begin
        if (bus.sub) begin
            b_eff_s = ~bus.b;
            c0_s    = 1'b1;
        end else begin
            b_eff_s = bus.b;
            c0_s    = bus.cin;
        end
    end

    // Valid bits, inter-group carries and the MSB overflow flag advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else if (!stall_s) begin
            v_q[0] <= bus.in_valid;
            c_q[0] <= c0_s;
            for (int k = 0; k < STAGES; k++) begin
                v_q[k+1] <= v_q[k];
                c_q[k+1] <= co_s[k];
            end
            ovf_q <= (|(c3_s & MSB_GRP_SEL)) ^ co_s[STAGES-1];
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_grp
        logic [CLA_GROUP-1:0] a_q   [j+1];
        logic [CLA_GROUP-1:0] b_q   [j+1];
        logic [CLA_GROUP-1:0] sum_q [STAGES-j];
        logic [CLA_GROUP-1:0] sum_s;

        // Group j operands wait j registers for their carry; its sum waits for the top group.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i <= j; i++) begin
                    a_q[i] <= '0;
                    b_q[i] <= '0;
                end
                for (int i = 0; i < STAGES - j; i++) begin
                    sum_q[i] <= '0;
                end
            end else if (!stall_s) begin
                a_q[0] <= bus.a[CLA_GROUP*j +: CLA_GROUP];
                b_q[0] <= b_eff_s[CLA_GROUP*j +: CLA_GROUP];
                for (int i = 1; i <= j; i++) begin
                    a_q[i] <= a_q[i-1];
                    b_q[i] <= b_q[i-1];
                end
                sum_q[0] <= sum_s;
                for (int i = 1; i < STAGES - j; i++) begin
                    sum_q[i] <= sum_q[i-1];
                end
            end
        end

        cla_group4 u_grp (
            .a_i  (a_q[j]),
            .b_i  (b_q[j]),
            .ci_i (c_q[j]),
            .s_o  (sum_s),
            .co_o (co_s[j]),
            .c3_o (c3_s[j])
        );

        assign s_s[CLA_GROUP*j +: CLA_GROUP] = sum_q[STAGES-1-j];
    end

    assign bus.out_valid = v_q[STAGES];
    assign bus.s         = s_s;
    assign bus.cout      = c_q[STAGES];
    assign bus.ovf       = ovf_q;

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, one group per pipeline stage. It supports WIDTH-bit operands, an add/subtract mode, and carry-out and signed-overflow flags. A valid/ready handshake provides full-throughput streaming with backpressure. It is the arithmetic datapath successor to the combinational 4-bit lookahead adder and sits between operand-producing logic and any result consumer.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- STAGES, derived constant WIDTH/4; it is not overridable and equals the pipeline depth.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  the block accepts a beat this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 selects a+b+cin; 1 selects a-b, computed as a+~b+1.
- out_valid  output  1  result beat present.
- out_ready  input  1  the consumer accepts a result this cycle.
- s  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1. For subtraction, 1 means no borrow.
- ovf  output  1  signed overflow. It is the carry into the MSB XOR the carry out of the MSB.

## Operation
- A beat transfers on a rising edge when in_valid && in_ready. A result transfers when out_valid && out_ready.
- stall = out_valid && !out_ready, and in_ready = !stall. When stall=0, every stage register advances together. When stall=1, every stage register holds.
- Bubbles are not squeezed out. An invalid beat advances like a valid beat, with its valid bit set to 0.
- Operand preprocessing happens at the input: b_eff = sub ? ~b : b, and c0 = sub ? 1 : cin.
- Stage k (k = 0..STAGES-1) computes bits [4k+3:4k] with one lookahead group, using the carry registered by stage k-1. Stage 0 uses c0.
- Operands are skewed. Group j of a/b_eff is delayed j stage registers so that it reaches stage j together with its carry.
- Result bits are de-skewed. Group k is delayed STAGES-1-k further registers, so that all groups of one beat emerge together.
- Each stage carries a valid bit and the group carry-out. The final stage also registers the carry into the MSB for ovf.
- Output registers hold their value while stall=1. When out_valid=0, the values of s, cout and ovf are don't-care, except directly after reset.
- Reset, including mid-operation: all valid bits clear immediately and all in-flight beats are discarded. s=0, cout=0, ovf=0, out_valid=0. in_ready is 1 while rst is asserted and after reset.

## Timing
- Latency is STAGES cycles. A beat accepted at edge n appears with out_valid=1 after edge n+STAGES-1+1, that is, STAGES edges after acceptance.
- Throughput is one beat per cycle when out_ready stays 1.
- in_ready is combinational from out_ready and out_valid. There is no other combinational input-to-output path.
- in_valid and out_ready may be asserted in the same cycle while a stall is clearing. The pipeline advances and the new beat enters on that same edge.
- Critical path is one 4-bit lookahead group plus its carry register; it is independent of WIDTH.

## Structure
- Shared package cla_pkg: the group size constant CLA_GROUP=4, and the functions grp_p/grp_g (group propagate/generate).
- Sub-module cla_group4 takes a[3:0], b[3:0] and ci, and returns s[3:0], co and c3. c3 is the carry into bit 3, used for ovf at the top group. It is instantiated STAGES times via generate.
- Skew and de-skew delay lines are generate-loop registers with a shared enable, !stall.

## Test plan
All scenarios use WIDTH=16, so latency is 4 cycles.
- Reset: assert rst asynchronously mid-stream. Required: out_valid=0, s=0, cout=0 and ovf=0 immediately. No pre-reset beat ever appears afterwards.
- Add with carry: a=0x1234, b=0x0001, cin=1, sub=0. Required: s=0x1236, cout=0, ovf=0, exactly 4 cycles after acceptance.
- Carry across all groups: a=0xFFFF, b=0x0001, cin=0. Required: s=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001. Required: s=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1, where cin must be ignored. Required: s=0xFFFE, cout=0. Then a=0x8000, b=0x0001, sub=1. Required: s=0x7FFF, cout=1, ovf=1.
- Streaming and backpressure: 8 back-to-back random beats with out_ready toggled pseudo-randomly. Required: results match a reference model in order, with no loss or duplication. in_ready=0 exactly when out_valid && !out_ready. Outputs stay stable during a stall.
